bram_loader: RTL and testbench

Frame-load front end for the source image BRAM (`blk_mem_gen_0`, port A). It accepts a byte stream of one MAX_ROW×MAX_COL grayscale frame over a valid/ready handshake and writes it in raster order to addresses 0..MAX_ROW*MAX_COL-1. It can optionally read the frame back and compare a modular checksum. It is the writer for the image that `memory_controller` later fetches for mode 1 and mode 2 processing. BRAM ownership is arbitrated externally through a grant input.

---
 rtl/bram_loader_pkg.sv | 24 ++
 rtl/bram_loader_if.sv | 25 ++
 rtl/bram_loader_raster_counter.sv | 49 ++++
 rtl/bram_loader.sv | 164 ++++++++++++++++
 tb/tb_bram_loader.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/bram_loader_pkg.sv
// Shared types and constants for the frame loader: FSM state encoding,
// checksum width and frame-size helpers.
package bram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        VERIFY = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } loader_state_t;

    localparam int CSUM_W      = 16;
    localparam int DEF_MAX_ROW = 540;
    localparam int DEF_MAX_COL = 540;

    // Pixel count of a rows x cols frame; used to size the last-pixel compare.
    function automatic int frame_pix(input int rows, input int cols);
        return rows * cols;
    endfunction

    localparam int FRAME_PIX = DEF_MAX_ROW * DEF_MAX_COL;

endpackage

// File: rtl/bram_loader_if.sv
// Byte-stream and BRAM port A signals of the loader. The master modport is
// the loader (drives the BRAM, accepts bytes); the slave modport is the
// byte source plus BRAM side.
interface bram_loader_if #(
    parameter int ADDR_W = 19
);
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              ena_o;
    logic              wea_o;
    logic [ADDR_W-1:0] addr_o;
    logic [7:0]        d2mem_o;
    logic [7:0]        mem2d_i;

    modport master (
        input  byte_i, byte_valid_i, mem2d_i,
        output byte_ready_o, ena_o, wea_o, addr_o, d2mem_o
    );

    modport slave (
        output byte_i, byte_valid_i, mem2d_i,
        input  byte_ready_o, ena_o, wea_o, addr_o, d2mem_o
    );
endinterface

// File: rtl/bram_loader_raster_counter.sv
// Raster row/column/address counter shared by the write and readback phases.
// Clear has priority over advance; last_o flags the final pixel address.
module raster_counter
    import bram_loader_pkg::*;
#(
    parameter int MAX_ROW = 540,
    parameter int MAX_COL = 540,
    parameter int ADDR_W  = 19,
    parameter int ROW_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ROW_W-1:0]  row_o,
    output logic              last_o
);
    localparam int FRAME = frame_pix(MAX_ROW, MAX_COL);
    localparam int COL_W = $clog2(MAX_COL + 1);

    logic [ADDR_W-1:0] r_addr;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic              w_col_wrap;

    assign w_col_wrap = (r_col == COL_W'(MAX_COL - 1));
    assign last_o     = (r_addr == ADDR_W'(FRAME - 1));
    assign addr_o     = r_addr;
    assign row_o      = r_row;

    // Step through the frame in raster order; column wrap bumps the row.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            r_addr <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (adv_i) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/bram_loader.sv
// Frame loader: writes one MAX_ROW x MAX_COL byte frame into BRAM port A in
// raster order, optionally reads it back and compares a 16-bit modular sum.
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter int MAX_ROW = 540,
    parameter int MAX_COL = 540,
    parameter int ADDR_W  = 19,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              verify_en_i,
    input  logic              abort_i,
    input  logic              bram_gnt_i,
    bram_loader_if.master     bus,
    output logic              busy_o,
    output logic              load_done_o,
    output logic              verify_ok_o,
    output logic [CSUM_W-1:0] checksum_o,
    output logic [9:0]        cnt_row_o
);
    loader_state_t     r_state;
    logic              r_verify_en;
    logic              r_ena;
    logic              r_wea;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_d2mem;
    logic              r_load_done;
    logic              r_verify_ok;
    logic [CSUM_W-1:0] r_checksum;
    logic [CSUM_W-1:0] r_wsum;
    logic [CSUM_W-1:0] r_rsum;
    // Bit 0 mirrors a read strobe on ena_o; bit RD_LAT marks the cycle its
    // data is present on mem2d_i.
    logic [RD_LAT:0]   r_vpipe;

    logic              w_xfer;
    logic              w_rd_issue;
    logic              w_last;
    logic              w_cnt_clr;
    logic              w_pipe_idle;
    logic [ADDR_W-1:0] w_cnt_addr;
    logic [9:0]        w_row;
    logic [CSUM_W-1:0] w_wsum_next;
    logic [CSUM_W-1:0] w_rsum_next;

    assign w_xfer      = (r_state == LOAD) && bram_gnt_i && bus.byte_valid_i;
    assign w_rd_issue  = (r_state == VERIFY) && bram_gnt_i;
    assign w_pipe_idle = ~|r_vpipe[RD_LAT-1:0];
    assign w_wsum_next = r_wsum + CSUM_W'(bus.byte_i);
    assign w_rsum_next = r_rsum + (r_vpipe[RD_LAT] ? CSUM_W'(bus.mem2d_i) : CSUM_W'(0));

    // Counter restarts on a new load, an abort and at each phase end, so
    // VERIFY begins reading from address 0.
    assign w_cnt_clr = abort_i
                     || ((r_state == IDLE) && start_i)
                     || (w_xfer && w_last)
                     || (w_rd_issue && w_last);

    raster_counter #(
        .MAX_ROW (MAX_ROW),
        .MAX_COL (MAX_COL),
        .ADDR_W  (ADDR_W),
        .ROW_W   (10)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_cnt_clr),
        .adv_i  (w_xfer || w_rd_issue),
        .addr_o (w_cnt_addr),
        .row_o  (w_row),
        .last_o (w_last)
    );

    assign bus.byte_ready_o = (r_state == LOAD) && bram_gnt_i;
    assign bus.ena_o        = r_ena;
    assign bus.wea_o        = r_wea;
    assign bus.addr_o       = r_addr;
    assign bus.d2mem_o      = r_d2mem;
    assign busy_o           = (r_state != IDLE);
    assign load_done_o      = r_load_done;
    assign verify_ok_o      = r_verify_ok;
    assign checksum_o       = r_checksum;
    assign cnt_row_o        = w_row;

    // Loader FSM with registered BRAM strobes, checksums and status outputs.
    // Abort leaves the strobe registered on its edge intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_verify_en <= 1'b0;
            r_ena       <= 1'b0;
            r_wea       <= 1'b0;
            r_addr      <= '0;
            r_d2mem     <= '0;
            r_load_done <= 1'b0;
            r_verify_ok <= 1'b0;
            r_checksum  <= '0;
            r_wsum      <= '0;
            r_rsum      <= '0;
            r_vpipe     <= '0;
        end else begin
            r_ena       <= w_xfer || w_rd_issue;
            r_wea       <= w_xfer;
            r_load_done <= 1'b0;
            r_vpipe     <= {r_vpipe[RD_LAT-1:0], w_rd_issue};
            if (w_xfer || w_rd_issue) r_addr  <= w_cnt_addr;
            if (w_xfer)               r_d2mem <= bus.byte_i;
            if (w_xfer)               r_wsum  <= w_wsum_next;
            if (r_vpipe[RD_LAT])      r_rsum  <= w_rsum_next;

            if (abort_i) begin
                r_state     <= IDLE;
                r_verify_en <= 1'b0;
                r_verify_ok <= 1'b0;
                r_wsum      <= '0;
                r_rsum      <= '0;
                r_vpipe     <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start_i) begin
                            r_state     <= LOAD;
                            r_verify_en <= verify_en_i;
                            r_wsum      <= '0;
                            r_rsum      <= '0;
                            r_verify_ok <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (w_xfer && w_last) begin
                            if (r_verify_en) begin
                                r_state <= VERIFY;
                            end else begin
                                r_state    <= DONE;
                                r_checksum <= w_wsum_next;
                            end
                        end
                    end
                    VERIFY: begin
                        if (w_rd_issue && w_last) r_state <= DRAIN;
                    end
                    DRAIN: begin
                        // Leave once the only outstanding read is the one
                        // whose data is being summed this cycle.
                        if (w_pipe_idle) begin
                            r_verify_ok <= (w_rsum_next == r_wsum);
                            r_checksum  <= r_wsum;
                            r_state     <= DONE;
                        end
                    end
                    DONE: begin
                        r_load_done <= 1'b1;
                        r_state     <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: a 4x4 instance with a BRAM model driven
// from a vector table, plus a 540x16 instance for row-count and checksum wrap.
module tb_bram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0, verify_en_i = 1'b0, abort_i = 1'b0, bram_gnt_i = 1'b0;
    logic        busy_o, load_done_o, verify_ok_o;
    logic [15:0] checksum_o;
    logic [9:0]  cnt_row_o;

    logic        b_start = 1'b0;
    logic        b_busy, b_done, b_ok;
    logic [15:0] b_csum;
    logic [9:0]  b_row;

    int checks = 0;
    int errors = 0;

    bram_loader_if #(.ADDR_W(4))  bus_s ();
    bram_loader_if #(.ADDR_W(14)) bus_b ();

    always #5 clk = ~clk;

    bram_loader #(.MAX_ROW(4), .MAX_COL(4), .ADDR_W(4), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .verify_en_i(verify_en_i),
        .abort_i(abort_i), .bram_gnt_i(bram_gnt_i), .bus(bus_s),
        .busy_o(busy_o), .load_done_o(load_done_o), .verify_ok_o(verify_ok_o),
        .checksum_o(checksum_o), .cnt_row_o(cnt_row_o)
    );

    bram_loader #(.MAX_ROW(540), .MAX_COL(16), .ADDR_W(14), .RD_LAT(1)) dut_big (
        .clk(clk), .rst(rst), .start_i(b_start), .verify_en_i(1'b0),
        .abort_i(1'b0), .bram_gnt_i(1'b1), .bus(bus_b),
        .busy_o(b_busy), .load_done_o(b_done), .verify_ok_o(b_ok),
        .checksum_o(b_csum), .cnt_row_o(b_row)
    );

    // BRAM model with one cycle read latency; optional +1 corruption at addr 7
    logic [7:0] mem [0:15];
    logic       corrupt = 1'b0;
    always @(posedge clk) begin
        if (bus_s.ena_o && bus_s.wea_o) mem[bus_s.addr_o] <= bus_s.d2mem_o;
        if (bus_s.ena_o && !bus_s.wea_o)
            bus_s.mem2d_i <= mem[bus_s.addr_o] + ((corrupt && bus_s.addr_o == 4'd7) ? 8'd1 : 8'd0);
    end

    typedef struct {
        bit verify;
        int pat;
        int gap_lo;
        int gap_hi;
        bit corrupt;
        int start2;
        int abort_pix;
        int rst_pix;
        int exp_wr;
        int exp_rd;
        int exp_done;
        bit exp_ok;
        int exp_csum;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [7:0] pat(input int p, input int i);
        int t;
        t = (p == 0) ? i : (15 * i + 3);
        return t[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int idx = 0, wcnt = 0, rcnt = 0, dcyc = -1, dn = 0, lim;
        bit fired = 1'b0;
        corrupt = v.corrupt;
        lim = (v.exp_done > 0) ? v.exp_done + 4 : 24;
        for (int c = 0; c < lim; c++) begin
            if (bus_s.ena_o && bus_s.wea_o) begin
                chk($sformatf("v%0d wr_addr", n), 32'(bus_s.addr_o), wcnt);
                chk($sformatf("v%0d wr_data", n), 32'(bus_s.d2mem_o), 32'(pat(v.pat, wcnt)));
                wcnt++;
            end
            if (bus_s.ena_o && !bus_s.wea_o) begin
                chk($sformatf("v%0d rd_addr", n), 32'(bus_s.addr_o), rcnt);
                rcnt++;
            end
            if (v.gap_lo >= 0 && c >= v.gap_lo + 1 && c <= v.gap_hi + 1)
                chk($sformatf("v%0d gap_ena c%0d", n, c), 32'(bus_s.ena_o), 0);
            if (load_done_o) begin
                dn++;
                dcyc = c;
            end
            if (c == 1) chk($sformatf("v%0d busy", n), 32'(busy_o), 1);

            start_i            = (c == 0) || (c == v.start2);
            verify_en_i        = v.verify;
            bram_gnt_i         = !(c >= v.gap_lo && c <= v.gap_hi);
            bus_s.byte_valid_i = (idx < 16);
            bus_s.byte_i       = pat(v.pat, idx);
            abort_i            = 1'b0;
            rst                = 1'b0;
            if (!fired && c > 0 && idx == v.abort_pix) begin abort_i = 1'b1; fired = 1'b1; end
            if (!fired && c > 0 && idx == v.rst_pix)   begin rst = 1'b1;     fired = 1'b1; end
            #1;
            if (c >= v.gap_lo && c <= v.gap_hi)
                chk($sformatf("v%0d gap_ready c%0d", n, c), 32'(bus_s.byte_ready_o), 0);
            if (bus_s.byte_ready_o && bus_s.byte_valid_i) idx++;
            @(posedge clk);
            #1;
        end
        start_i = 1'b0; abort_i = 1'b0; rst = 1'b0; bus_s.byte_valid_i = 1'b0;
        chk($sformatf("v%0d wr_count", n), wcnt, v.exp_wr);
        chk($sformatf("v%0d rd_count", n), rcnt, v.exp_rd);
        chk($sformatf("v%0d done_pulses", n), dn, (v.exp_done > 0) ? 1 : 0);
        if (v.exp_done > 0) chk($sformatf("v%0d done_cycle", n), dcyc, v.exp_done);
        chk($sformatf("v%0d checksum", n), 32'(checksum_o), v.exp_csum);
        chk($sformatf("v%0d verify_ok", n), 32'(verify_ok_o), 32'(v.exp_ok));
        chk($sformatf("v%0d busy_end", n), 32'(busy_o), 0);
        $display("vec %0d: writes %0d reads %0d done_cycle %0d checksum %0d verify_ok %0d",
                 n, wcnt, rcnt, dcyc, checksum_o, verify_ok_o);
    endtask

    initial begin
        int bdc, bdn, bmax;
        //          ver pat glo ghi cor st2 abt rst  wr  rd done ok csum
        vecs[0] = '{0, 0, -1, -1, 0, -1, -1, -1, 16, 0,  18, 0, 120};
        vecs[1] = '{0, 0,  5,  8, 0, -1, -1, -1, 16, 0,  22, 0, 120};
        vecs[2] = '{1, 0, -1, -1, 0, -1, -1, -1, 16, 16, 36, 1, 120};
        vecs[3] = '{1, 0, -1, -1, 1, -1, -1, -1, 16, 16, 36, 0, 120};
        vecs[4] = '{1, 1, 20, 22, 0, -1, -1, -1, 16, 16, 39, 1, 1848};
        vecs[5] = '{0, 1, -1, -1, 0,  5, -1, -1, 16, 0,  18, 0, 1848};
        vecs[6] = '{0, 0, -1, -1, 0, -1,  9, -1, 10, 0,  -1, 0, 1848};
        vecs[7] = '{0, 0, -1, -1, 0, -1, -1, -1, 16, 0,  18, 0, 120};
        vecs[8] = '{0, 0, -1, -1, 0, -1, -1,  5,  5, 0,  -1, 0, 0};
        vecs[9] = '{1, 1, -1, -1, 0, -1, -1, -1, 16, 16, 36, 1, 1848};

        bus_s.byte_i = 8'd0; bus_s.byte_valid_i = 1'b0;
        bus_b.byte_i = 8'hFF; bus_b.byte_valid_i = 1'b1; bus_b.mem2d_i = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bram_gnt_i = 1'b1;
        #1;
        chk("rst ready", 32'(bus_s.byte_ready_o), 0);
        chk("rst ena", 32'(bus_s.ena_o), 0);
        chk("rst wea", 32'(bus_s.wea_o), 0);
        chk("rst addr", 32'(bus_s.addr_o), 0);
        chk("rst d2mem", 32'(bus_s.d2mem_o), 0);
        chk("rst busy", 32'(busy_o), 0);
        chk("rst done", 32'(load_done_o), 0);
        chk("rst verify_ok", 32'(verify_ok_o), 0);
        chk("rst checksum", 32'(checksum_o), 0);
        chk("rst cnt_row", 32'(cnt_row_o), 0);
        $display("reset: busy %0d ena %0d checksum %0d", busy_o, bus_s.ena_o, checksum_o);

        // start together with abort in IDLE: abort wins
        @(posedge clk); #1;
        start_i = 1'b1; abort_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; abort_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("start+abort busy c%0d", k), 32'(busy_o), 0);
            chk($sformatf("start+abort done c%0d", k), 32'(load_done_o), 0);
            @(posedge clk); #1;
        end
        $display("start+abort in idle: busy %0d", busy_o);

        for (int n = 0; n < 10; n++) run_vec(n, vecs[n]);

        // 540x16 frame of 0xFF: row counter reaches 539, checksum wraps
        bdc = -1; bdn = 0; bmax = 0;
        for (int c = 0; c < 8660; c++) begin
            if (b_done) begin bdn++; bdc = c; end
            if (int'(b_row) > bmax) bmax = int'(b_row);
            b_start = (c == 0);
            @(posedge clk); #1;
        end
        b_start = 1'b0;
        chk("big done_pulses", bdn, 1);
        chk("big done_cycle", bdc, 8642);
        chk("big checksum", 32'(b_csum), 32'h9E40);
        chk("big max_row", bmax, 539);
        chk("big busy_end", 32'(b_busy), 0);
        $display("big frame: done_cycle %0d checksum 0x%04h max_row %0d", bdc, b_csum, bmax);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
